// File: rtl/data_memory_ws_if.sv
// Request/response bundle between the MEM stage and data_memory_ws.
// Master drives address/data/controls; slave returns readData/busy/ready/error.
interface data_memory_ws_if;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memRead;
    logic        memWrite;
    logic [1:0]  size;
    logic        unsignedLoad;
    logic [31:0] readData;
    logic        busy;
    logic        ready;
    logic        error;

    modport master (
        output address, writeData, memRead, memWrite, size, unsignedLoad,
        input  readData, busy, ready, error
    );

    modport slave (
        input  address, writeData, memRead, memWrite, size, unsignedLoad,
        output readData, busy, ready, error
    );
endinterface

// File: rtl/data_memory_ws.sv
// Wait-state byte/half/word data memory for the MEM stage.
// Ports: clk, rstN (async active-low), bus (data_memory_ws_if.slave).
module data_memory_ws #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rstN,
    data_memory_ws_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    size_q, size_d;
    logic          uns_q, uns_d;
    logic          rd_q, rd_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic          busy_q, busy_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          mem_we;
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic          bad;
    logic [3:0]    wmask;
    logic [31:0]   wal;
    logic [31:0]   cur;
    logic [31:0]   merged;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [31:0]   load_val;
    logic          unused_addr;

    assign unused_addr = ^bus.address[31:AW+2];

    assign idx = addr_q[AW+1:2];
    assign off = addr_q[1:0];
    assign cur = mem[idx];

    assign bad = (size_q == 2'b11)
               | ((size_q == 2'b01) & off[0])
               | ((size_q == 2'b10) & (off != 2'b00));

    // Lane mask and replicated store data so any lane picks up its bytes.
    always_comb begin
        wmask = 4'b0000;
        wal   = wdata_q;
        unique case (size_q)
            2'b00: begin
                wmask = 4'b0001 << off;
                wal   = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                wmask = off[1] ? 4'b1100 : 4'b0011;
                wal   = {2{wdata_q[15:0]}};
            end
            default: begin
                wmask = 4'b1111;
                wal   = wdata_q;
            end
        endcase
    end

    // Post-store view of the word: a combined load+store reads this.
    always_comb begin
        merged = cur;
        if (wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    merged[8*i +: 8] = wal[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        lane_b   = merged[{off, 3'b000} +: 8];
        lane_h   = merged[{off[1], 4'b0000} +: 16];
        load_val = merged;
        unique case (size_q)
            2'b00: load_val = uns_q ? {24'd0, lane_b}
                                    : {{24{lane_b[7]}}, lane_b};
            2'b01: load_val = uns_q ? {16'd0, lane_h}
                                    : {{16{lane_h[15]}}, lane_h};
            default: load_val = merged;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        error_d = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.memRead | bus.memWrite) begin
                    addr_d  = bus.address[AW+1:0];
                    wdata_d = bus.writeData;
                    size_d  = bus.size;
                    uns_d   = bus.unsignedLoad;
                    rd_d    = bus.memRead;
                    wr_d    = bus.memWrite;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    ready_d = 1'b1;
                    error_d = bad;
                    mem_we  = wr_q & ~bad;
                    if (bad) begin
                        rdata_d = 32'd0;
                    end else if (rd_q) begin
                        rdata_d = load_val;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            rdata_q <= 32'd0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
            busy_q  <= busy_d;
        end
    end

    // Array has no reset; contents survive rstN.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= merged;
        end
    end

    assign bus.readData = rdata_q;
    assign bus.ready    = ready_q;
    assign bus.error    = error_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_data_memory_ws.sv
// Bench for data_memory_ws: two instances (WAIT_STATES 2 and 0) on shared
// inputs, checked every cycle against a latency/byte-array model.
module tb_data_memory_ws;
    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    data_memory_ws_if b2 ();
    data_memory_ws_if b0 ();

    assign b0.address      = b2.address;
    assign b0.writeData    = b2.writeData;
    assign b0.memRead      = b2.memRead;
    assign b0.memWrite     = b2.memWrite;
    assign b0.size         = b2.size;
    assign b0.unsignedLoad = b2.unsignedLoad;

    data_memory_ws #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rstN(rstN), .bus(b2));
    data_memory_ws #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rstN(rstN), .bus(b0));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: index 0 is the WAIT_STATES=0 instance, 1 is WAIT_STATES=2.
    logic [7:0]  m_mem [2][1024];
    bit          pend [2];
    int          done_at [2];
    logic [31:0] ca [2];
    logic [31:0] cd [2];
    logic [1:0]  cs [2];
    bit          cu [2];
    bit          cr [2];
    bit          cw [2];
    bit          e_rdy [2];
    bit          e_err [2];
    logic [31:0] e_rd [2];
    int          edge_n = 0;

    task automatic complete(int k);
        bit bad;
        int nb;
        int base;
        logic [31:0] v;
        bad = (cs[k] == 2'b11) || (cs[k] == 2'b01 && ca[k][0])
           || (cs[k] == 2'b10 && ca[k][1:0] != 2'b00);
        nb = (cs[k] == 2'b00) ? 1 : (cs[k] == 2'b01) ? 2 : 4;
        base = int'(ca[k][9:0]);
        if (cw[k] && !bad)
            for (int i = 0; i < nb; i++) m_mem[k][base+i] = cd[k][8*i +: 8];
        if (bad) e_rd[k] = 32'd0;
        else if (cr[k]) begin
            v = 32'd0;
            for (int i = 0; i < nb; i++) v[8*i +: 8] = m_mem[k][base+i];
            if (!cu[k] && nb == 1 && v[7]) v = v | 32'hFFFF_FF00;
            if (!cu[k] && nb == 2 && v[15]) v = v | 32'hFFFF_0000;
            e_rd[k] = v;
        end
        e_rdy[k] = 1'b1;
        e_err[k] = bad;
    endtask

    task automatic step(int k);
        int ws;
        ws = (k == 1) ? 2 : 0;
        e_rdy[k] = 1'b0;
        e_err[k] = 1'b0;
        if (pend[k]) begin
            if (edge_n == done_at[k]) complete(k);
            else if (edge_n == done_at[k] + 1) pend[k] = 1'b0;
        end else if (b2.memRead || b2.memWrite) begin
            pend[k] = 1'b1;
            done_at[k] = edge_n + ws + 1;
            ca[k] = b2.address;
            cd[k] = b2.writeData;
            cs[k] = b2.size;
            cu[k] = b2.unsignedLoad;
            cr[k] = b2.memRead;
            cw[k] = b2.memWrite;
        end
    endtask

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int k = 0; k < 2; k++) begin
                pend[k] = 1'b0;
                e_rdy[k] = 1'b0;
                e_err[k] = 1'b0;
                e_rd[k] = 32'd0;
            end
        end else begin
            edge_n++;
            step(0);
            step(1);
        end
    end

    always @(negedge clk) begin
        chk("ws0_busy", {31'd0, b0.busy}, {31'd0, pend[0]});
        chk("ws0_ready", {31'd0, b0.ready}, {31'd0, e_rdy[0]});
        chk("ws0_error", {31'd0, b0.error}, {31'd0, e_err[0]});
        chk("ws0_rdata", b0.readData, e_rd[0]);
        chk("ws2_busy", {31'd0, b2.busy}, {31'd0, pend[1]});
        chk("ws2_ready", {31'd0, b2.ready}, {31'd0, e_rdy[1]});
        chk("ws2_error", {31'd0, b2.error}, {31'd0, e_err[1]});
        chk("ws2_rdata", b2.readData, e_rd[1]);
    end

    // Issue a request and hold it until the chosen instance reports ready.
    task automatic access(input bit use0, input bit r, input bit w,
                          input logic [1:0] sz, input bit u,
                          input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rdv, output bit errv,
                          output int lat);
        bit seen;
        b2.address = a;
        b2.writeData = d;
        b2.size = sz;
        b2.unsignedLoad = u;
        b2.memRead = r;
        b2.memWrite = w;
        lat = 0;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            lat++;
            seen = use0 ? b0.ready : b2.ready;
        end
        if (!seen) chk("ready_timeout", 32'd0, 32'd1);
        rdv = use0 ? b0.readData : b2.readData;
        errv = use0 ? b0.error : b2.error;
        b2.memRead = 1'b0;
        b2.memWrite = 1'b0;
        for (int i = 0; i < 40 && (b2.busy || b0.busy); i++)
            @(negedge clk);
        if (b2.busy || b0.busy) chk("idle_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    logic [31:0] rdv;
    bit errv;
    int lat;

    initial begin
        b2.address = 32'd0;
        b2.writeData = 32'd0;
        b2.size = 2'b00;
        b2.unsignedLoad = 1'b0;
        b2.memRead = 1'b0;
        b2.memWrite = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'd0, b2.busy}, 32'd0);
        chk("rst_ready", {31'd0, b2.ready}, 32'd0);
        chk("rst_rdata", b2.readData, 32'd0);
        #2 rstN = 1'b1;
        @(negedge clk);

        access(0, 0, 1, 2'b10, 0, 32'h28, 32'hDEAD0000, rdv, errv, lat);
        chk("st_lat_ws2", lat, 32'd4);
        chk("st_err", {31'd0, errv}, 32'd0);
        access(0, 1, 0, 2'b10, 0, 32'h28, 32'd0, rdv, errv, lat);
        chk("ld_word", rdv, 32'hDEAD0000);

        access(0, 0, 1, 2'b00, 0, 32'h29, 32'h000000EF, rdv, errv, lat);
        access(0, 1, 0, 2'b10, 0, 32'h28, 32'd0, rdv, errv, lat);
        chk("ld_word_b", rdv, 32'hDEADEF00);
        access(0, 1, 0, 2'b00, 0, 32'h29, 32'd0, rdv, errv, lat);
        chk("ld_byte_s", rdv, 32'hFFFFFFEF);
        access(0, 1, 0, 2'b00, 1, 32'h29, 32'd0, rdv, errv, lat);
        chk("ld_byte_u", rdv, 32'h000000EF);
        access(0, 1, 0, 2'b01, 0, 32'h2A, 32'd0, rdv, errv, lat);
        chk("ld_half_s", rdv, 32'hFFFFDEAD);

        access(0, 0, 1, 2'b10, 0, 32'h2A, 32'h12345678, rdv, errv, lat);
        chk("mis_err", {31'd0, errv}, 32'd1);
        chk("mis_rdata", rdv, 32'd0);
        access(0, 0, 1, 2'b11, 0, 32'h28, 32'h12345678, rdv, errv, lat);
        chk("rsv_err", {31'd0, errv}, 32'd1);
        chk("rsv_rdata", rdv, 32'd0);
        access(0, 1, 0, 2'b10, 0, 32'h28, 32'd0, rdv, errv, lat);
        chk("ld_after_err", rdv, 32'hDEADEF00);

        access(0, 1, 1, 2'b10, 0, 32'h48, 32'h0000BEEF, rdv, errv, lat);
        chk("rw_rdata", rdv, 32'h0000BEEF);

        b2.address = 32'h28;
        b2.writeData = 32'hCAFEF00D;
        b2.size = 2'b10;
        b2.memWrite = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rstN = 1'b0;
        #1;
        chk("arst_busy", {31'd0, b2.busy}, 32'd0);
        chk("arst_ready", {31'd0, b2.ready}, 32'd0);
        chk("arst_rdata", b2.readData, 32'd0);
        b2.memWrite = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        @(negedge clk);
        access(0, 1, 0, 2'b10, 0, 32'h28, 32'd0, rdv, errv, lat);
        chk("ld_after_rst", rdv, 32'hDEADEF00);

        access(1, 0, 1, 2'b10, 0, 32'h428, 32'h55AA55AA, rdv, errv, lat);
        chk("st_lat_ws0", lat, 32'd2);
        access(0, 1, 0, 2'b10, 0, 32'h028, 32'd0, rdv, errv, lat);
        chk("alias_ws2", rdv, 32'h55AA55AA);
        chk("alias_ws0", b0.readData, 32'h55AA55AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
